// File: rtl/led_display_arbiter.sv
// Arbitrates two writers onto the eight LED digit registers and drives the scan strobe.
// Optional brightness control is compiled in with `define LED_DIM_EN (adds the dim input).
module led_display_arbiter #(
    parameter int SCAN_DIV    = 50000,
    parameter int HOLD_FRAMES = 250
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       a_req,
    input  logic [2:0] a_idx,
    input  logic [7:0] a_data,
    output logic       a_ack,
    input  logic       b_req,
    input  logic [2:0] b_idx,
    input  logic [7:0] b_data,
    output logic       b_ack,
`ifdef LED_DIM_EN
    input  logic [2:0] dim,
`endif
    output logic       scan_tick,
    output logic       b_owner,
    output logic [7:0] LED0,
    output logic [7:0] LED1,
    output logic [7:0] LED2,
    output logic [7:0] LED3,
    output logic [7:0] LED4,
    output logic [7:0] LED5,
    output logic [7:0] LED6,
    output logic [7:0] LED7,
    output logic       led_blank
);

    localparam int CW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;

    typedef enum logic {
        SHARE = 1'b0,
        HOLD  = 1'b1
    } state_t;

    state_t      state;
    logic        rr_b;
    logic [11:0] frame_cnt;
    logic [CW-1:0] pre_cnt;
    logic [2:0]  slot;
    logic        frame_end;
    logic        last_frame;
    logic [7:0]  led_q [8];

    assign scan_tick  = (pre_cnt == CW'(SCAN_DIV - 1));
    assign frame_end  = scan_tick && (slot == 3'd7);
    assign last_frame = ({1'b0, frame_cnt} + 13'd1) >= 13'(HOLD_FRAMES);
    assign b_owner    = (state == HOLD);

    assign LED0 = led_q[0];
    assign LED1 = led_q[1];
    assign LED2 = led_q[2];
    assign LED3 = led_q[3];
    assign LED4 = led_q[4];
    assign LED5 = led_q[5];
    assign LED6 = led_q[6];
    assign LED7 = led_q[7];

    // Grant decision: B owns the display in HOLD, round-robin on contention in SHARE.
    always_comb begin
        a_ack = 1'b0;
        b_ack = 1'b0;
        if (rst) begin
            if (state == HOLD) begin
                b_ack = b_req;
            end else begin
                a_ack = a_req & (~b_req | ~rr_b);
                b_ack = b_req & (~a_req | rr_b);
            end
        end
    end

    // Prescaler and slot counter; scanning runs regardless of write traffic.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pre_cnt <= '0;
            slot    <= 3'd0;
        end else begin
            if (scan_tick) begin
                pre_cnt <= '0;
                slot    <= slot + 3'd1;
            end else begin
                pre_cnt <= pre_cnt + CW'(1);
            end
        end
    end

    // Ownership FSM with round-robin pointer and saturating hold frame counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= SHARE;
            rr_b      <= 1'b0;
            frame_cnt <= 12'd0;
        end else begin
            unique case (state)
                SHARE: begin
                    frame_cnt <= 12'd0;
                    if (a_ack || b_ack) begin
                        rr_b <= a_ack;
                    end
                    if (b_ack) begin
                        state <= HOLD;
                    end
                end
                HOLD: begin
                    if (b_ack) begin
                        frame_cnt <= 12'd0;
                    end else if (frame_end) begin
                        if (frame_cnt != 12'hFFF) begin
                            frame_cnt <= frame_cnt + 12'd1;
                        end
                        if (last_frame) begin
                            state <= SHARE;
                            rr_b  <= 1'b0;
                        end
                    end
                end
                default: begin
                    state <= SHARE;
                end
            endcase
        end
    end

    // Digit registers; at most one writer is acked per cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 8; i++) begin
                led_q[i] <= 8'hFF;
            end
        end else begin
            if (a_ack) begin
                led_q[a_idx] <= a_data;
            end
            if (b_ack) begin
                led_q[b_idx] <= b_data;
            end
        end
    end

`ifdef LED_DIM_EN
    localparam int TW = CW + 1;

    logic [TW-1:0] thr;
    logic [23:0]   prod;

    assign prod      = (24'(dim) + 24'd1) * 24'(SCAN_DIV);
    assign led_blank = ({1'b0, pre_cnt} >= thr);

    // Blank threshold latched per slot so a dim change lands on a slot boundary.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            thr <= TW'(SCAN_DIV);
        end else if (scan_tick) begin
            thr <= TW'(prod >> 3);
        end
    end
`else
    assign led_blank = 1'b0;
`endif

endmodule

// File: tb/tb_led_display_arbiter.sv
// Randomized scoreboard bench for led_display_arbiter.
// A spec-level ownership model predicts acks, LEDs, ownership and scan strobes.
module tb_led_display_arbiter;

    localparam int SD = 4;
    localparam int HF = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic       a_req, b_req;
    logic [2:0] a_idx, b_idx;
    logic [7:0] a_data, b_data;
    logic       a_ack, b_ack;
    logic       scan_tick, b_owner, led_blank;
    logic [7:0] LED0, LED1, LED2, LED3, LED4, LED5, LED6, LED7;
`ifdef LED_DIM_EN
    logic [2:0] dim = 3'd7;
`endif

    always #5 clk = ~clk;

    led_display_arbiter #(.SCAN_DIV(SD), .HOLD_FRAMES(HF)) dut (
        .clk(clk), .rst(rst),
        .a_req(a_req), .a_idx(a_idx), .a_data(a_data), .a_ack(a_ack),
        .b_req(b_req), .b_idx(b_idx), .b_data(b_data), .b_ack(b_ack),
`ifdef LED_DIM_EN
        .dim(dim),
`endif
        .scan_tick(scan_tick), .b_owner(b_owner),
        .LED0(LED0), .LED1(LED1), .LED2(LED2), .LED3(LED3),
        .LED4(LED4), .LED5(LED5), .LED6(LED6), .LED7(LED7),
        .led_blank(led_blank)
    );

    logic [63:0] dut_leds;
    assign dut_leds = {LED7, LED6, LED5, LED4, LED3, LED2, LED1, LED0};

    typedef struct packed {
        logic        ea;
        logic        eb;
        logic        own;
        logic        tick;
        logic [63:0] leds;
    } st_t;

    typedef struct packed {
        logic       who;
        logic [2:0] idx;
        logic [7:0] data;
    } txn_t;

    st_t  sq[$];
    txn_t tq[$];

    int errors = 0;
    int checks = 0;
    bit mon_en = 0;
    bit run = 0;

    bit         chk_pend = 0;
    logic [2:0] chk_idx;
    logic [7:0] chk_data;

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Monitor: compares per-cycle status and pops a transfer on every ack.
    always @(negedge clk) begin
        if (mon_en) begin
            st_t  s;
            txn_t t;
            if (chk_pend) begin
                chk("led_write", 64'(dut_leds[chk_idx*8 +: 8]), 64'(chk_data));
                chk_pend = 0;
            end
            if (sq.size() > 0) begin
                s = sq.pop_front();
                chk("a_ack", 64'(a_ack), 64'(s.ea));
                chk("b_ack", 64'(b_ack), 64'(s.eb));
                chk("b_owner", 64'(b_owner), 64'(s.own));
                chk("scan_tick", 64'(scan_tick), 64'(s.tick));
                chk("led_blank", 64'(led_blank), 64'd0);
                chk("leds", dut_leds, s.leds);
            end else if (run) begin
                chk("status_depth", 64'(sq.size()), 64'd1);
            end
            if (a_ack || b_ack) begin
                if (tq.size() == 0) begin
                    chk("txn_depth", 64'(tq.size()), 64'd1);
                end else begin
                    t = tq.pop_front();
                    chk("txn_who", 64'(b_ack), 64'(t.who));
                    chk_idx  = t.idx;
                    chk_data = t.data;
                    chk_pend = 1;
                end
            end
        end
    end

    logic [7:0] m_led [8];
    bit         own, ptr_b, a_pend, b_pend, ea, eb, tick, fe;
    int         frames, k;
    logic [63:0] pk;

    initial begin
        rst    = 1'b0;
        a_req  = 1'b1;
        b_req  = 1'b1;
        a_idx  = 3'd0;
        b_idx  = 3'd0;
        a_data = 8'h00;
        b_data = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_leds", dut_leds, {8{8'hFF}});
        chk("rst_a_ack", 64'(a_ack), 64'd0);
        chk("rst_b_ack", 64'(b_ack), 64'd0);
        chk("rst_owner", 64'(b_owner), 64'd0);
        chk("rst_tick", 64'(scan_tick), 64'd0);
        chk("rst_blank", 64'(led_blank), 64'd0);
        a_req = 1'b0;
        b_req = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        for (int i = 0; i < 8; i++) m_led[i] = 8'hFF;
        own = 0; ptr_b = 0; frames = 0; k = 0;
        a_pend = 0; b_pend = 0;
        mon_en = 1;
        run = 1;
        for (int c = 0; c < 3000; c++) begin
            tick = (k % SD) == SD - 1;
            fe   = (k % (8 * SD)) == 8 * SD - 1;
            if (!a_pend && $urandom_range(2) == 0) begin
                a_pend = 1;
                a_idx  = 3'($urandom());
                a_data = 8'($urandom());
            end
            if (!b_pend && ($urandom_range(47) == 0 ||
                (own && fe && frames == HF - 1 && $urandom_range(1) == 0))) begin
                b_pend = 1;
                b_idx  = 3'($urandom());
                b_data = 8'($urandom());
            end
            a_req = a_pend;
            b_req = b_pend;
            if (own) begin
                ea = 0;
                eb = b_pend;
            end else if (a_pend && b_pend) begin
                ea = !ptr_b;
                eb = ptr_b;
            end else begin
                ea = a_pend;
                eb = b_pend;
            end
            for (int i = 0; i < 8; i++) pk[i*8 +: 8] = m_led[i];
            sq.push_back('{ea: ea, eb: eb, own: own, tick: tick, leds: pk});
            if (ea) tq.push_back('{who: 1'b0, idx: a_idx, data: a_data});
            if (eb) tq.push_back('{who: 1'b1, idx: b_idx, data: b_data});
            @(posedge clk);
            if (ea) m_led[a_idx] = a_data;
            if (eb) m_led[b_idx] = b_data;
            if (!own) begin
                if (ea || eb) ptr_b = ea;
                if (eb) begin
                    own = 1;
                    frames = 0;
                end
            end else if (eb) begin
                frames = 0;
            end else if (fe) begin
                if (frames < 4095) frames++;
                if (frames >= HF) begin
                    own = 0;
                    ptr_b = 0;
                end
            end
            k++;
            if (ea) a_pend = 0;
            if (eb) b_pend = 0;
            #1;
        end
        run = 0;
        a_req = 1'b0;
        b_req = 1'b0;
        @(negedge clk);
        #1;
        mon_en = 0;
        chk("status_left", 64'(sq.size()), 64'd0);
        chk("txn_left", 64'(tq.size()), 64'd0);

        b_req  = 1'b1;
        b_idx  = 3'd5;
        b_data = 8'h92;
        @(posedge clk);
        #1;
        b_req  = 1'b0;
        a_req  = 1'b1;
        a_idx  = 3'd0;
        a_data = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        chk("hold_owner", 64'(b_owner), 64'd1);
        chk("hold_led5", 64'(LED5), 64'h92);
        chk("hold_a_stall", 64'(a_ack), 64'd0);
        #2;
        rst   = 1'b0;
        b_req = 1'b1;
        #1;
        chk("arst_led5", 64'(LED5), 64'hFF);
        chk("arst_owner", 64'(b_owner), 64'd0);
        chk("arst_a_ack", 64'(a_ack), 64'd0);
        chk("arst_b_ack", 64'(b_ack), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("rel_a_ack", 64'(a_ack), 64'd1);
        chk("rel_b_ack", 64'(b_ack), 64'd0);
        @(posedge clk);
        #1;
        chk("rel_led0", 64'(LED0), 64'h00);
        chk("rr_a_ack", 64'(a_ack), 64'd0);
        chk("rr_b_ack", 64'(b_ack), 64'd1);
        chk("rr_owner", 64'(b_owner), 64'd0);
        a_req = 1'b0;
        b_req = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
